wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Parametrised writeback arbiter; replaces the fixed four-input writeback merge.
- Collects results from NUM_CH execution channels (ALU, LSU, MUL, DIV, future units) into per-channel queues.
- Selects one result per cycle by round-robin and drives the single register-file write port, which also feeds the dispatcher forwarding/scoreboard interface.
- Per-channel ready gives each execution unit backpressure; producers stall while their queue is full.

Parameters:
- NUM_CH, 4, number of execution-unit result channels (2..8).
- DEPTH, 2, entries per channel queue; power of two, >= 2.
- XLEN, 32, result data width.
- RA_W, 5, destination register address width.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of all queued results and the output register.
- ch_valid  in  NUM_CH  per-channel result valid.
- ch_rd  in  NUM_CH*RA_W  per-channel destination register; channel i occupies bits [i*RA_W +: RA_W].
- ch_data  in  NUM_CH*XLEN  per-channel result; channel i occupies bits [i*XLEN +: XLEN].
- ch_ready  out  NUM_CH  queue i can accept an entry this cycle.
- wb_en  out  1  register-file write enable.
- wb_rd  out  RA_W  write address.
- wb_data  out  XLEN  write data.
- wb_src  out  $clog2(NUM_CH)  channel that produced the current write.
- busy  out  1  any queue non-empty or wb_en high.

Behaviour:
- Reset (asynchronous, while rst=1):
  - All queue counts and pointers are 0.
  - wb_en=0, wb_rd=0, wb_data=0, wb_src=0.
  - Round-robin pointer = NUM_CH-1, so channel 0 has first priority.
  - ch_ready=all ones, busy=0.
- Push: on a rising edge where ch_valid[i] && ch_ready[i] && ch_rd[i]!=0, queue i stores {rd,data} at its write pointer.
  - If ch_rd[i]==0 the result is discarded (x0) and handshakes as accepted.
  - ch_valid while ch_ready=0 is dropped. This is a producer protocol violation; the bench flags it with an assertion.
- ch_ready[i] = (count_i < DEPTH), taken from the registered count only.
  - A full queue is not ready in a cycle where it pops; there is no same-cycle pass-through.
- Arbitration (combinational on registered state):
  - Candidate set = non-empty queues.
  - Grant = first candidate scanning from (rr_ptr+1) mod NUM_CH upward with wrap.
  - On grant, the head entry of that queue is popped and rr_ptr <= grant.
  - With no candidates, rr_ptr holds.
- Output register: every edge, wb_en <= any candidate.
  - When a grant occurs: wb_rd, wb_data <= head entry; wb_src <= grant.
  - Otherwise wb_rd, wb_data and wb_src hold their values and wb_en=0.
- Latency: ch_valid at cycle t (accepted) -> wb_en at cycle t+2 at the earliest (empty queues, channel wins arbitration).
- Throughput: one write per cycle total. A channel contending with K others waits at most K grants.
- Ordering: FIFO within each channel; no ordering guarantee across channels.
- Simultaneous push and pop on the same queue: count unchanged, both pointers advance, each wrapping modulo DEPTH.
- flush=1 at an edge:
  - All counts and pointers clear, wb_en <= 0, rr_ptr <= NUM_CH-1.
  - Pushes presented in that cycle are discarded.
  - flush has priority over push and pop.
- rst asserted mid-operation: immediate return to the reset state. Queued results are lost, and no partial write is emitted after rst deasserts.
- busy is combinational from registered state.

Decomposition:
- Shared package: wb_entry_t struct {rd[RA_W-1:0], data[XLEN-1:0]}, and constant WB_MAX_CH=8.
- Sub-module wb_chan_fifo: one DEPTH-entry queue with count, push/pop, flush and ch_ready. It is instantiated NUM_CH times via a generate loop.
- The round-robin arbiter stays inline in wb_arbiter.

Test Plan:
- Single result: reset, then ch_valid[2]=1, rd=7, data=32'hDEADBEEF for one cycle -> exactly two cycles later wb_en=1, wb_rd=7, wb_data=32'hDEADBEEF, wb_src=2, then wb_en=0 and busy=0.
- x0 drop: ch_valid[0]=1, rd=0, data=32'h1234 -> ch_ready[0] stays 1 and wb_en never asserts.
- Fairness: all four channels push one entry in the same cycle -> wb_src sequence 0,1,2,3 on four consecutive cycles. A second identical burst after rr_ptr=3 also yields 0,1,2,3.
- Backpressure: DEPTH=2, hold channel 1 valid with data 1,2,3 while channels 0, 2 and 3 flood:
  - ch_ready[1] drops after two accepts.
  - Data 3 is accepted only after channel 1 is granted.
  - Channel 1 writes appear in order 1,2,3.
- Flush mid-stream: 3 entries queued across channels; assert flush for 1 cycle while channel 0 pushes -> next cycle wb_en=0 and busy=0, and no queued or flush-cycle data is ever written.
- Asynchronous reset mid-stream: assert rst between clock edges with queues non-empty -> wb_en=0 and ch_ready=all ones immediately. After release, the first write comes only from new pushes.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared types and limits for the writeback arbiter and its per-channel queues.
package wb_arbiter_pkg;

  localparam int unsigned WB_MAX_CH = 8;
  localparam int unsigned WB_RA_W   = 5;
  localparam int unsigned WB_XLEN   = 32;

  typedef struct packed {
    logic [WB_RA_W-1:0] rd;
    logic [WB_XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_chan_fifo.sv
// One execution-channel result queue: DEPTH entries, registered count,
// flush clears everything, ready/head/non-empty are combinational views.
module wb_chan_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter type         entry_t = wb_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   push,
  input  logic   pop,
  input  entry_t din,
  output entry_t head_c,
  output logic   ready_c,
  output logic   nonempty_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("wb_chan_fifo: DEPTH must be a power of two >= 2");
  end

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // Ready comes only from the registered count: no pass-through when full.
  assign ready_c    = (count < CNT_W'(DEPTH));
  assign nonempty_c = (count != '0);
  assign head_c     = mem[rptr];
  assign do_push    = push && ready_c && !flush;
  assign do_pop     = pop && nonempty_c && !flush;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_W'(1);
      if (do_pop)  rptr <= rptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-channel result queues, round-robin selection of one
// result per cycle onto the registered register-file write port.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned XLEN   = WB_XLEN,
  parameter int unsigned RA_W   = WB_RA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [NUM_CH-1:0]          ch_valid,
  input  logic [NUM_CH*RA_W-1:0]     ch_rd,
  input  logic [NUM_CH*XLEN-1:0]     ch_data,
  output logic [NUM_CH-1:0]          ch_ready,
  output logic                       wb_en,
  output logic [RA_W-1:0]            wb_rd,
  output logic [XLEN-1:0]            wb_data,
  output logic [$clog2(NUM_CH)-1:0]  wb_src,
  output logic                       busy
);

  localparam int unsigned SRC_W = $clog2(NUM_CH);

  if (NUM_CH < 2 || NUM_CH > WB_MAX_CH) begin : g_bad_num_ch
    $error("wb_arbiter: NUM_CH must be in 2..WB_MAX_CH");
  end

  typedef struct packed {
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] data;
  } entry_t;

  entry_t             din  [NUM_CH];
  entry_t             head [NUM_CH];
  entry_t             head_sel;
  logic [NUM_CH-1:0]  push;
  logic [NUM_CH-1:0]  pop;
  logic [NUM_CH-1:0]  nonempty;
  logic [SRC_W-1:0]   rr_ptr;
  logic [SRC_W-1:0]   grant;
  logic [SRC_W-1:0]   scan_idx;
  logic               grant_vld;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Writes to x0 handshake normally but never enter the queue.
    assign din[i]  = {ch_rd[i*RA_W +: RA_W], ch_data[i*XLEN +: XLEN]};
    assign push[i] = ch_valid[i] && (ch_rd[i*RA_W +: RA_W] != '0);
    assign pop[i]  = grant_vld && (grant == SRC_W'(i));

    wb_chan_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
    ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .push       (push[i]),
      .pop        (pop[i]),
      .din        (din[i]),
      .head_c     (head[i]),
      .ready_c    (ch_ready[i]),
      .nonempty_c (nonempty[i])
    );
  end

  // Round-robin: first non-empty queue after the last grant, with wrap.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    scan_idx  = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      scan_idx = SRC_W'((32'(rr_ptr) + k) % NUM_CH);
      if (!grant_vld && nonempty[scan_idx]) begin
        grant_vld = 1'b1;
        grant     = scan_idx;
      end
    end
  end

  assign head_sel = head[grant];

  // Registered write port; payload holds when nothing is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en   <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
      wb_src  <= '0;
      rr_ptr  <= SRC_W'(NUM_CH - 1);
    end else if (flush) begin
      wb_en  <= 1'b0;
      rr_ptr <= SRC_W'(NUM_CH - 1);
    end else begin
      wb_en <= grant_vld;
      if (grant_vld) begin
        wb_rd   <= head_sel.rd;
        wb_data <= head_sel.data;
        wb_src  <= grant;
        rr_ptr  <= grant;
      end
    end
  end

  assign busy = (|nonempty) || wb_en;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with a per-channel expected-result scoreboard.
module tb_wb_arbiter;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned RA_W   = 5;
  localparam int unsigned SRC_W  = 2;
  localparam int unsigned EW     = RA_W + XLEN;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   flush = 1'b0;
  logic [NUM_CH-1:0]      ch_valid = '0;
  logic [NUM_CH*RA_W-1:0] ch_rd = '0;
  logic [NUM_CH*XLEN-1:0] ch_data = '0;
  logic [NUM_CH-1:0]      ch_ready;
  logic                   wb_en;
  logic [RA_W-1:0]        wb_rd;
  logic [XLEN-1:0]        wb_data;
  logic [SRC_W-1:0]       wb_src;
  logic                   busy;

  wb_arbiter #(
    .NUM_CH (NUM_CH),
    .DEPTH  (DEPTH),
    .XLEN   (XLEN),
    .RA_W   (RA_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .ch_valid (ch_valid),
    .ch_rd    (ch_rd),
    .ch_data  (ch_data),
    .ch_ready (ch_ready),
    .wb_en    (wb_en),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .wb_src   (wb_src),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int              passed = 0;
  int              total  = 0;
  int              fails  = 0;
  logic [EW-1:0]   exp_q [NUM_CH][$];
  int              wr_cnt [NUM_CH];
  logic [XLEN-1:0] ch1_log [$];
  logic [EW-1:0]   mon_e;
  int              p1;
  bit              acc1;
  logic [XLEN-1:0] fd;
  int              pending;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic v, input logic [RA_W-1:0] rd,
                        input logic [XLEN-1:0] d);
    ch_valid[ch]               = v;
    ch_rd[ch*RA_W +: RA_W]     = rd;
    ch_data[ch*XLEN +: XLEN]   = d;
    if (v && ch_ready[ch] && rd != '0 && !flush) exp_q[ch].push_back({rd, d});
  endtask

  task automatic idle();
    ch_valid = '0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < int'(NUM_CH); i++) begin
      exp_q[i].delete();
      wr_cnt[i] = 0;
    end
    ch1_log.delete();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 64 && busy; i++) tick();
    chk(tag, 64'(busy), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_model();
    @(posedge clk);
    #3;
    rst = 1'b0;
    tick();
  endtask

  // Scoreboard: every write must match the oldest expected entry of its channel.
  always @(negedge clk) begin
    if (!rst && wb_en) begin
      chk("write_expected", 64'(exp_q[wb_src].size() != 0), 64'd1);
      if (exp_q[wb_src].size() != 0) begin
        mon_e = exp_q[wb_src].pop_front();
        chk("wb_rd", 64'(wb_rd), 64'(mon_e[EW-1 -: RA_W]));
        chk("wb_data", 64'(wb_data), 64'(mon_e[XLEN-1:0]));
      end
      wr_cnt[wb_src]++;
      if (wb_src == SRC_W'(1)) ch1_log.push_back(wb_data);
    end
  end

  // Producers in this bench must never offer a result to a full queue.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        assert (!(ch_valid[i] && !ch_ready[i]))
        else $error("FAIL protocol ch%0d: valid=1 with ready=0, expected valid held low", i);
      end
    end
  end

  initial begin
    clear_model();
    #1;
    chk("rst_wb_en", 64'(wb_en), 64'd0);
    chk("rst_wb_rd", 64'(wb_rd), 64'd0);
    chk("rst_wb_data", 64'(wb_data), 64'd0);
    chk("rst_wb_src", 64'(wb_src), 64'd0);
    chk("rst_ch_ready", 64'(ch_ready), 64'hF);
    chk("rst_busy", 64'(busy), 64'd0);
    #11;
    rst = 1'b0;
    tick();

    // Single result: visible exactly two edges after being offered.
    set_ch(2, 1'b1, 5'd7, 32'hDEADBEEF);
    tick();
    idle();
    chk("single_t1_wb_en", 64'(wb_en), 64'd0);
    tick();
    chk("single_wb_en", 64'(wb_en), 64'd1);
    chk("single_wb_rd", 64'(wb_rd), 64'd7);
    chk("single_wb_data", 64'(wb_data), 64'hDEADBEEF);
    chk("single_wb_src", 64'(wb_src), 64'd2);
    tick();
    chk("single_after_wb_en", 64'(wb_en), 64'd0);
    chk("single_after_busy", 64'(busy), 64'd0);

    // x0 destination is accepted and dropped.
    set_ch(0, 1'b1, 5'd0, 32'h1234);
    tick();
    idle();
    chk("x0_ready", 64'(ch_ready[0]), 64'd1);
    tick();
    tick();
    chk("x0_wb_en", 64'(wb_en), 64'd0);
    chk("x0_busy", 64'(busy), 64'd0);

    // Fairness: two simultaneous bursts from reset pointer.
    do_reset();
    for (int b = 0; b < 2; b++) begin
      for (int c = 0; c < int'(NUM_CH); c++) set_ch(c, 1'b1, 5'(c + 1), 32'(100 * b + c));
      tick();
      idle();
      for (int k = 0; k < int'(NUM_CH); k++) begin
        tick();
        chk($sformatf("fair_b%0d_en%0d", b, k), 64'(wb_en), 64'd1);
        chk($sformatf("fair_b%0d_src%0d", b, k), 64'(wb_src), 64'(k));
      end
      tick();
      chk($sformatf("fair_b%0d_idle", b), 64'(busy), 64'd0);
    end

    // Backpressure: channel 1 sends 1,2,3 while 0,2,3 flood.
    clear_model();
    p1 = 0;
    fd = 32'h100;
    for (int c = 0; c < 14; c++) begin
      for (int ch = 0; ch < int'(NUM_CH); ch++) begin
        if (ch != 1) begin
          set_ch(ch, ch_ready[ch], 5'(20 + ch), fd);
          fd++;
        end
      end
      acc1 = 1'b0;
      if (p1 < 3 && ch_ready[1]) begin
        set_ch(1, 1'b1, 5'd11, 32'(p1 + 1));
        acc1 = 1'b1;
      end else begin
        set_ch(1, 1'b0, '0, '0);
      end
      tick();
      if (acc1) begin
        p1++;
        if (p1 == 2) chk("bp_ready1_low", 64'(ch_ready[1]), 64'd0);
        if (p1 == 3) chk("bp_d3_after_grant", 64'(wr_cnt[1] >= 1), 64'd1);
      end
    end
    idle();
    chk("bp_all_accepted", 64'(p1), 64'd3);
    drain("bp_drain");
    chk("bp_ch1_count", 64'(ch1_log.size()), 64'd3);
    for (int i = 0; i < 3 && i < ch1_log.size(); i++)
      chk($sformatf("bp_ch1_order%0d", i), 64'(ch1_log[i]), 64'(i + 1));

    // Flush with three queued results and a concurrent push.
    set_ch(1, 1'b1, 5'd3, 32'hA1);
    set_ch(2, 1'b1, 5'd4, 32'hA2);
    set_ch(3, 1'b1, 5'd5, 32'hA3);
    tick();
    idle();
    chk("flush_pre_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    clear_model();
    set_ch(0, 1'b1, 5'd6, 32'hF00);
    tick();
    flush = 1'b0;
    idle();
    chk("flush_wb_en", 64'(wb_en), 64'd0);
    chk("flush_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 3; i++) tick();
    chk("flush_quiet", 64'(busy), 64'd0);

    // Asynchronous reset between edges with queues populated.
    set_ch(0, 1'b1, 5'd8, 32'hB0);
    set_ch(1, 1'b1, 5'd9, 32'hB1);
    set_ch(2, 1'b1, 5'd10, 32'hB2);
    tick();
    idle();
    tick();
    chk("arst_pre_en", 64'(wb_en), 64'd1);
    chk("arst_pre_src", 64'(wb_src), 64'd0);
    #2;
    rst = 1'b1;
    clear_model();
    #1;
    chk("arst_wb_en", 64'(wb_en), 64'd0);
    chk("arst_ready", 64'(ch_ready), 64'hF);
    chk("arst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    tick();
    chk("arst_post_en", 64'(wb_en), 64'd0);
    chk("arst_post_busy", 64'(busy), 64'd0);
    set_ch(3, 1'b1, 5'd9, 32'h55);
    tick();
    idle();
    tick();
    chk("arst_new_en", 64'(wb_en), 64'd1);
    chk("arst_new_src", 64'(wb_src), 64'd3);
    chk("arst_new_data", 64'(wb_data), 64'h55);
    drain("arst_drain");

    pending = 0;
    for (int i = 0; i < int'(NUM_CH); i++) pending += exp_q[i].size();
    chk("scoreboard_empty", 64'(pending), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
